// File: rtl/sram_pipe_clr.sv
// sram_pipe_clr: parametrised 1R1W SRAM with hardware clear sweep, busy/valid status and range protection.
// Optional same-edge read-after-write bypass is enabled by defining SRAM_PIPE_BYPASS_EN.
module sram_pipe_clr #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EN_M,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR_WRITE,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  output logic              BUSY
);
  typedef enum logic {SWEEP, RUN} state_t;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d, raddr_q, raddr_d, waddr_q, waddr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                we_q, we_d, dv_q, dv_d, accept, rd_ok, wr_ok;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      dv_q    <= dv_d;
    end

  // The counter parks on the last word instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == SWEEP) begin
      state_d = cnt_q == LAST ? RUN : SWEEP;
      cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
    end else if (CLR) begin
      state_d = SWEEP;
      cnt_d   = '0;
    end
  end

  // A CLR edge drops any new read or write presented alongside it.
  always_comb begin
    BUSY    = state_q == SWEEP;
    accept  = !BUSY && !CLR;
    we_d    = accept && WE;
    waddr_d = accept ? ADDR_WRITE : waddr_q;
    din_d   = accept ? DIN : din_q;
    raddr_d = accept && EN_M ? ADDR : raddr_q;
    dv_d    = accept && EN_M;
  end

  always_ff @(posedge CLK)
    if (BUSY) mem[cnt_q] <= '0;
    else if (we_q && wr_ok) mem[waddr_q] <= din_q;

  assign rd_ok      = {1'b0, raddr_q} < LIMIT;
  assign wr_ok      = {1'b0, waddr_q} < LIMIT;
  assign DOUT_VALID = dv_q;
`ifdef SRAM_PIPE_BYPASS_EN
  assign DOUT = BUSY || !rd_ok ? '0 : we_q && waddr_q == raddr_q ? din_q : mem[raddr_q];
`else
  assign DOUT = BUSY || !rd_ok ? '0 : mem[raddr_q];
`endif
endmodule
